// File: rtl/next_pc_ctrl_pkg.sv
// Shared encodings for the next-PC controller: branch kinds, FSM states, PC step.
package next_pc_ctrl_pkg;
  localparam logic [1:0]  BR_COND = 2'b00;
  localparam logic [1:0]  BR_JAL  = 2'b01;
  localparam logic [1:0]  BR_JALR = 2'b10;
  localparam logic [1:0]  BR_RSVD = 2'b11;
  localparam logic [31:0] PC_INC  = 32'd4;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_REQ   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;
endpackage

// File: rtl/PCimm.sv
// Target adder: base + signed immediate, 32-bit wrap.
module PCimm (
  input  logic [31:0] PC,
  input  logic [31:0] Imm,
  output logic [31:0] Sum
);
  assign Sum = PC + Imm;
endmodule

// File: rtl/next_pc_ctrl.sv
// Next-PC / fetch-request controller with branch redirect and flush pulse.
// Define PC_MISALIGN_TRAP_EN to trap misaligned targets to TRAP_VEC.
module next_pc_ctrl
  import next_pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [1:0]  br_kind,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_imm,
  input  logic [31:0] br_rs1,
  input  logic        stall,
  output logic        if_req,
  output logic [31:0] if_addr,
  input  logic        if_ack,
  output logic [31:0] pc,
  output logic        flush,
  output logic        trap
);
  state_e      state;
  logic [31:0] base, sum, target, redir_pc;
  logic        redirect;

  assign base = (br_kind == BR_JALR) ? br_rs1 : br_pc;

  PCimm u_pcimm (
    .PC  (base),
    .Imm (br_imm),
    .Sum (sum)
  );

  assign target   = (br_kind == BR_JALR) ? {sum[31:1], 1'b0} : sum;
  // Redirects win over stall and the sequential advance; ignored while booting.
  assign redirect = br_valid && br_taken && (br_kind != BR_RSVD) && (state != S_BOOT);

  assign if_req  = (state == S_REQ) && !stall;
  assign if_addr = pc;

`ifdef PC_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = |target[1:0];
  assign redir_pc = misalign ? TRAP_VEC : target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trap <= 1'b0;
    else        trap <= redirect && misalign;
  end
`else
  assign redir_pc = target & ~32'd3;
  assign trap     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      state <= S_BOOT;
      flush <= 1'b0;
    end else begin
      flush <= redirect;
      if (redirect) begin
        pc    <= redir_pc;
        state <= S_FLUSH;
      end else begin
        if (if_req && if_ack) pc <= pc + PC_INC;
        state <= S_REQ;
      end
    end
  end
endmodule

// File: tb/tb_next_pc_ctrl.sv
// Self-checking bench for next_pc_ctrl: directed scenarios plus randomized run vs a model.
module tb_next_pc_ctrl;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TVEC   = 32'h0000_0100;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        br_valid = 0, br_taken = 0, stall = 0, if_ack = 0;
  logic [1:0]  br_kind = 0;
  logic [31:0] br_pc = 0, br_imm = 0, br_rs1 = 0;
  logic        if_req, flush, trap;
  logic [31:0] if_addr, pc;

  int n_cmp = 0, n_err = 0;

  // Reference model: architectural PC and phase (0 boot, 1 fetching, 2 flushing).
  logic [31:0] m_pc;
  int          m_phase;
  logic        m_flush, m_trap;

  next_pc_ctrl #(.RESET_PC(RST_PC), .TRAP_VEC(TVEC)) dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_taken(br_taken),
    .br_kind(br_kind), .br_pc(br_pc), .br_imm(br_imm), .br_rs1(br_rs1),
    .stall(stall), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .pc(pc), .flush(flush), .trap(trap)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    m_pc = RST_PC; m_phase = 0; m_flush = 0; m_trap = 0;
  endtask

  task automatic model_step();
    logic [31:0] t;
    if (m_phase != 0 && br_valid && br_taken && br_kind != 2'd3) begin
      if (br_kind == 2'd2) t = (br_rs1 + br_imm) & ~32'd1;
      else                 t = br_pc + br_imm;
`ifdef PC_MISALIGN_TRAP_EN
      if (t % 4 != 0) begin m_pc = TVEC; m_trap = 1; end
      else begin m_pc = t; m_trap = 0; end
`else
      m_pc = t - (t % 4); m_trap = 0;
`endif
      m_flush = 1; m_phase = 2;
    end else begin
      if (m_phase == 1 && !stall && if_ack) m_pc = m_pc + 4;
      m_flush = 0; m_trap = 0; m_phase = 1;
    end
  endtask

  // Advance one clock; returns just after the following falling edge.
  task automatic next();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive_br(input logic v, input logic [1:0] k, input logic [31:0] p,
                          input logic [31:0] i, input logic [31:0] r);
    br_valid = v; br_taken = v; br_kind = k; br_pc = p; br_imm = i; br_rs1 = r;
  endtask

  task automatic test_reset();
    rst_n = 0; if_ack = 1; stall = 0;
    m_reset();
    @(negedge clk); #1;
    n_cmp++;
    if ({pc, if_req, flush, trap} !== {RST_PC, 3'b000}) begin
      n_err++; $display("FAIL reset_state: got pc=%h req/fl/tr=%b%b%b want pc=%h 000", pc, if_req, flush, trap, RST_PC);
    end
    @(negedge clk);
    rst_n = 1; #1;
    n_cmp++;
    if (if_req !== 1'b0) begin n_err++; $display("FAIL boot_req: got %b want 0", if_req); end
    for (int i = 0; i < 3; i++) begin
      next(); #1;
      n_cmp++;
      if ({if_req, if_addr} !== {1'b1, 32'(i * 4)}) begin
        n_err++; $display("FAIL seq_addr%0d: got req=%b addr=%h want 1 %h", i, if_req, if_addr, 32'(i * 4));
      end
    end
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({if_req, pc} !== {1'b0, 32'h8}) begin
        n_err++; $display("FAIL stall%0d: got req=%b pc=%h want 0 00000008", i, if_req, pc);
      end
      next();
    end
    stall = 0; #1;
    n_cmp++;
    if ({if_req, if_addr} !== {1'b1, 32'h8}) begin
      n_err++; $display("FAIL unstall: got req=%b addr=%h want 1 00000008", if_req, if_addr);
    end
  endtask

  task automatic test_branch();
    drive_br(1, 2'b00, 32'h10, -32'sd8, 32'h0);
    next();
    drive_br(0, 2'b00, 0, 0, 0); #1;
    n_cmp++;
    if ({pc, flush, if_req} !== {32'h8, 2'b10}) begin
      n_err++; $display("FAIL branch_redir: got pc=%h fl=%b req=%b want 00000008 1 0", pc, flush, if_req);
    end
    next(); #1;
    n_cmp++;
    if ({if_req, if_addr, flush} !== {1'b1, 32'h8, 1'b0}) begin
      n_err++; $display("FAIL branch_refetch: got req=%b addr=%h fl=%b want 1 00000008 0", if_req, if_addr, flush);
    end
  endtask

  task automatic test_jalr();
    logic [31:0] exp_pc;
    logic        exp_trap;
`ifdef PC_MISALIGN_TRAP_EN
    exp_pc = 32'h100;  exp_trap = 1;
`else
    exp_pc = 32'h1000; exp_trap = 0;
`endif
    drive_br(1, 2'b10, 32'h0, 32'd2, 32'h1001);
    next();
    drive_br(0, 2'b00, 0, 0, 0); #1;
    n_cmp++;
    if ({pc, trap, flush} !== {exp_pc, exp_trap, 1'b1}) begin
      n_err++; $display("FAIL jalr_target: got pc=%h tr=%b fl=%b want %h %b 1", pc, trap, flush, exp_pc, exp_trap);
    end
    next(); #1;
    n_cmp++;
    if ({trap, flush, if_req} !== 3'b001) begin
      n_err++; $display("FAIL jalr_pulse: got tr/fl/req=%b%b%b want 001", trap, flush, if_req);
    end
  endtask

  task automatic test_hold();
    logic [31:0] held;
`ifdef PC_MISALIGN_TRAP_EN
    held = 32'h100;
`else
    held = 32'h1000;
`endif
    if_ack = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if ({if_req, if_addr} !== {1'b1, held}) begin
        n_err++; $display("FAIL hold%0d: got req=%b addr=%h want 1 %h", i, if_req, if_addr, held);
      end
      next();
    end
    drive_br(1, 2'b01, 32'h30, 32'h10, 32'h0);
    next();
    drive_br(0, 2'b00, 0, 0, 0); #1;
    n_cmp++;
    if ({pc, if_req, flush} !== {32'h40, 2'b01}) begin
      n_err++; $display("FAIL hold_redir: got pc=%h req=%b fl=%b want 00000040 0 1", pc, if_req, flush);
    end
    next();
    if_ack = 1; #1;
    n_cmp++;
    if ({if_req, if_addr} !== {1'b1, 32'h40}) begin
      n_err++; $display("FAIL hold_refetch: got req=%b addr=%h want 1 00000040", if_req, if_addr);
    end
    next();
  endtask

  task automatic test_async_reset();
    #2 rst_n = 0; #1;
    n_cmp++;
    if ({pc, if_req, flush, trap} !== {RST_PC, 3'b000}) begin
      n_err++; $display("FAIL async_reset: got pc=%h req/fl/tr=%b%b%b want %h 000", pc, if_req, flush, trap, RST_PC);
    end
    m_reset();
    @(posedge clk); @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_back_to_back();
    drive_br(1, 2'b01, 32'h200, 32'h20, 32'h0);
    next(); #1;
    n_cmp++;
    if ({pc, flush, if_req} !== {RST_PC, 2'b01}) begin
      n_err++; $display("FAIL boot_ignore: got pc=%h fl=%b req=%b want %h 0 1", pc, flush, if_req, RST_PC);
    end
    next(); #1;
    n_cmp++;
    if ({pc, flush} !== {32'h220, 1'b1}) begin
      n_err++; $display("FAIL b2b_first: got pc=%h fl=%b want 00000220 1", pc, flush);
    end
    drive_br(1, 2'b01, 32'h300, -32'sd16, 32'h0);
    next(); #1;
    n_cmp++;
    if ({pc, flush, if_req} !== {32'h2F0, 2'b10}) begin
      n_err++; $display("FAIL b2b_second: got pc=%h fl=%b req=%b want 000002f0 1 0", pc, flush, if_req);
    end
    drive_br(0, 2'b00, 0, 0, 0);
    next(); #1;
    n_cmp++;
    if ({flush, if_req, if_addr} !== {2'b01, 32'h2F0}) begin
      n_err++; $display("FAIL b2b_settle: got fl=%b req=%b addr=%h want 0 1 000002f0", flush, if_req, if_addr);
    end
  endtask

  task automatic test_random();
    logic        exp_req;
    for (int n = 0; n < 400; n++) begin
      if (n % 100 == 0) begin
        rst_n = 0; #1; m_reset();
        @(negedge clk); rst_n = 1;
      end
      br_valid = ($urandom_range(0, 3) == 0);
      br_taken = $urandom_range(0, 1);
      br_kind  = 2'($urandom_range(0, 3));
      br_pc    = $urandom & 32'hFFFF_FFFC;
      br_imm   = 32'($urandom_range(0, 64)) - 32'd32;
      br_rs1   = $urandom;
      stall    = ($urandom_range(0, 3) == 0);
      if_ack   = $urandom_range(0, 1);
      #1;
      exp_req = (m_phase == 1) && !stall;
      n_cmp++;
      if ({pc, if_addr, if_req, flush, trap} !== {m_pc, m_pc, exp_req, m_flush, m_trap}) begin
        n_err++;
        $display("FAIL random%0d: got pc=%h addr=%h req/fl/tr=%b%b%b want pc=%h req/fl/tr=%b%b%b",
                 n, pc, if_addr, if_req, flush, trap, m_pc, exp_req, m_flush, m_trap);
      end
      next();
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branch();
    test_jalr();
    test_hold();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
